// File: rtl/plane_tile_walker.sv
// plane_tile_walker: walks one tile in raster order, emitting x, y and the incrementally evaluated plane value
module plane_tile_walker #(
  parameter int TILE_W = 32,
  parameter int TILE_H = 32
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] ddx_i,
  input  logic [31:0] ddy_i,
  input  logic [31:0] c_i,
  input  logic [5:0]  tile_x_i,
  input  logic [5:0]  tile_y_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [11:0] out_x_o,
  output logic [11:0] out_y_o,
  output logic [31:0] out_val_o,
  output logic        out_last_o,
  output logic        busy_o
);
  localparam int XW = $clog2(TILE_W);
  localparam int YW = $clog2(TILE_H);
  typedef enum logic [1:0] {IDLE, INIT, WALK} state_t;
  state_t state_q;
  logic [31:0] ddx_q, ddy_q, c_q, row_acc_q, pix_acc_q;
  logic [11:0] ox_q, oy_q, out_x_q, out_y_q;
  logic [XW-1:0] x_cnt_q;
  logic [YW-1:0] y_cnt_q;
  logic out_valid_q, out_last_q;
  logic row_end, last_row;
  logic [31:0] acc_init_d;
  assign row_end = x_cnt_q == XW'(TILE_W - 1);
  assign last_row = y_cnt_q == YW'(TILE_H - 1);
  assign acc_init_d = {20'd0, ox_q} * ddx_q + {20'd0, oy_q} * ddy_q + c_q;
  assign in_ready_o = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign out_valid_o = out_valid_q;
  assign out_last_o = out_last_q;
  assign out_x_o = out_x_q;
  assign out_y_o = out_y_q;
  assign out_val_o = pix_acc_q;
  // Sequencer: latch coefficients, seed the accumulators at the tile origin, then step per accepted beat
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      ddx_q <= '0;
      ddy_q <= '0;
      c_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      row_acc_q <= '0;
      pix_acc_q <= '0;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          ddx_q <= ddx_i;
          ddy_q <= ddy_i;
          c_q <= c_i;
          ox_q <= 12'(tile_x_i) << XW;
          oy_q <= 12'(tile_y_i) << YW;
          state_q <= INIT;
        end
        INIT: begin
          row_acc_q <= acc_init_d;
          pix_acc_q <= acc_init_d;
          x_cnt_q <= '0;
          y_cnt_q <= '0;
          out_x_q <= ox_q;
          out_y_q <= oy_q;
          out_valid_q <= 1'b1;
          out_last_q <= 1'b0;
          state_q <= WALK;
        end
        WALK: if (out_ready_i) begin
          if (row_end && last_row) begin
            out_valid_q <= 1'b0;
            out_last_q <= 1'b0;
            state_q <= IDLE;
          end else if (row_end) begin
            x_cnt_q <= '0;
            y_cnt_q <= y_cnt_q + YW'(1);
            row_acc_q <= row_acc_q + ddy_q;
            pix_acc_q <= row_acc_q + ddy_q;
            out_x_q <= ox_q;
            out_y_q <= out_y_q + 12'd1;
            out_last_q <= 1'b0;
          end else begin
            x_cnt_q <= x_cnt_q + XW'(1);
            pix_acc_q <= pix_acc_q + ddx_q;
            out_x_q <= out_x_q + 12'd1;
            out_last_q <= (x_cnt_q == XW'(TILE_W - 2)) && last_row;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/plane_tile_walker.md
# plane_tile_walker

Pixel-sequencing front end for the PVR plane interpolator. Accepts one set of plane coefficients (ddx, ddy, c) plus a tile position over a valid/ready handshake. Walks every pixel of that tile in raster order and emits the screen coordinates and the plane value at each pixel. The value is computed incrementally (add ddx per pixel, ddy per row) instead of with per-pixel multiplies. It produces exactly the x*ddx + y*ddy + c stream that the combinational evaluator yields for the same x_ps/y_ps sequence, and it drives downstream per-pixel depth/shading consumers.

## Interface
- TILE_W, 32: tile width in pixels; power of two, 2..64.
- TILE_H, 32: tile height in pixels; power of two, 2..64.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  coefficient set offered.
- in_ready  out  1  block can accept a coefficient set.
- ddx  in  32 signed  per-pixel x step (same fixed-point scale as c).
- ddy  in  32 signed  per-row y step.
- c  in  32 signed  plane constant.
- tile_x  in  6  tile column; origin ox = tile_x*TILE_W.
- tile_y  in  6  tile row; origin oy = tile_y*TILE_H.
- out_valid  out  1  pixel beat valid.
- out_ready  in  1  downstream accepts beat.
- out_x  out  12 signed  pixel screen x.
- out_y  out  12 signed  pixel screen y.
- out_val  out  32 signed  plane value at (out_x, out_y).
- out_last  out  1  beat is final pixel of tile.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, INIT, WALK.
- IDLE: in_ready=1. On in_valid&in_ready, latch ddx, ddy, c, ox and oy, then go to INIT. in_ready is 0 in every other state. in_valid outside IDLE is ignored.
- INIT (1 cycle):
  - row_acc = pix_acc = ox*ddx + oy*ddy + c, truncated to 32 bits (two's-complement wrap).
  - x_cnt = y_cnt = 0.
  - Go to WALK.
- WALK outputs:
  - out_valid=1.
  - out_x = ox + x_cnt; out_y = oy + y_cnt (12-bit, wrap).
  - out_val = pix_acc.
  - out_last = (x_cnt==TILE_W-1 && y_cnt==TILE_H-1).
- WALK beat accepted (out_valid&out_ready), not row end: x_cnt+1; pix_acc += ddx.
- WALK beat accepted, row end (x_cnt==TILE_W-1) but not last: x_cnt=0; y_cnt+1; row_acc += ddy; pix_acc = row_acc + ddy (the new row start).
- WALK beat accepted with out_last=1: go to IDLE; out_valid drops the next cycle.
- WALK, out_ready=0: all outputs and accumulators hold.
- Arithmetic:
  - All accumulator additions are 32-bit wrapping.
  - The INIT products use a 12x32 multiply truncated to 32 bits.
  - Requirement: every out_val equals (out_x*ddx + out_y*ddy + c) mod 2^32 bit-exactly.
- Reset (reset_n=0 on a clock edge), from any state including mid-walk:
  - State returns to IDLE; counters and accumulators clear.
  - out_valid=0, out_last=0, busy=0, in_ready=1 on the following cycle.
  - The partial tile is discarded.

## Timing
- Reset values:
  - in_ready=1; busy=0.
  - out_valid=0; out_last=0.
  - out_x=0; out_y=0; out_val=0.
- Latency: input handshake in cycle N → INIT in N+1 → first out_valid in N+2.
- Throughput: 1 pixel per cycle while out_ready=1. A tile takes TILE_W*TILE_H beats + 2 cycles overhead.
- Back-to-back tiles:
  - in_ready rises the cycle after the last beat is accepted.
  - Minimum 3-cycle gap between the last beat of tile k and the first beat of tile k+1.
- Output stability: out_* are registered and stable while out_valid=1 and out_ready=0 (AXI-stream rule). out_valid never deasserts without a handshake, except on reset.

## Test plan
- Basic sweep: ddx=1, ddy=100, c=0, tile (0,0), out_ready=1 → 1024 beats. Required values:
  - (0,0): val 0.
  - (31,0): val 31.
  - (0,1): val 100.
  - (31,31): val 3131, out_last=1 on this beat only.
  - First out_valid 2 cycles after the input handshake.
- Offset tile with negative step: tile_x=2, tile_y=1, ddx=-3, ddy=5, c=1000 → first beat x=64, y=32, val 968; last beat x=95, y=63, val 1000-285+315=1030.
- Backpressure: random out_ready (~50%) with the basic sweep config → identical 1024-beat sequence to the out_ready=1 run. Outputs never change while stalled.
- Wraparound: ddx=0x7FFFFFFF, ddy=0x40000000, c=0x7FFFFFF0, tile (63,63) → every beat matches the mod-2^32 reference model; out_x/out_y wrap at 12 bits without error.
- Reset mid-walk: assert reset_n=0 for 1 cycle at beat 500 → next cycle out_valid=0, busy=0, in_ready=1. A fresh tile then walks correctly from (ox,oy).
- Handshake: hold in_valid=1 continuously across 3 tiles → exactly 3 accepts, each in a cycle with in_ready=1. Tiles are emitted in order with 3-cycle gaps.
